if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, 64'h0000_0000_8000_0000, address of the first fetch after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 if_req_valid  output  1  instruction-memory request valid.
REQ-005 if_req_ready  input  1  memory accepts the request this cycle.
REQ-006 if_req_addr  output  64  fetch address, word aligned.
REQ-007 if_resp_valid  input  1  response data valid, at most one per accepted request.
REQ-008 if_resp_data  input  32  fetched instruction word.
REQ-009 inst_valid  output  1  instruction available to the decode stage.
REQ-010 inst_ready  input  1  decode consumes the instruction this cycle.
REQ-011 inst  output  32  instruction to decode.
REQ-012 inst_addr  output  64  address of inst.
REQ-013 redirect_valid  input  1  branch/jump redirect this cycle.
REQ-014 redirect_addr  input  64  redirect target; bits [1:0] are ignored and treated as 0.

Function
REQ-015 States: S_IDLE, S_REQ, S_WAIT, S_HALT; registers: pc, req_addr, drop, 2-entry FIFO of {inst, inst_addr}, count 0..2.
REQ-016 if_req_valid SHALL be 1 only in S_REQ; if_req_addr SHALL equal req_addr and stay stable until accepted.
REQ-017 S_IDLE -> S_REQ when count <= 1 and no redirect; req_addr <= pc at that edge.
REQ-018 S_REQ with if_req_ready -> S_WAIT; pc <= req_addr + 4, modulo 2^64.
REQ-019 S_WAIT with if_resp_valid and drop=0: push {if_resp_data, req_addr}; -> S_IDLE.
REQ-020 At most one request is outstanding; the FIFO never overflows; a push to a full FIFO is impossible by construction.
REQ-021 inst_valid = (count != 0); inst/inst_addr show the FIFO head; pop on inst_valid & inst_ready; push and pop in the same cycle leave count unchanged.
REQ-022 Redirect: FIFO flushed (count <= 0); pc <= {redirect_addr[63:2], 2'b00}; inst_valid is 0 in the next cycle.
REQ-023 Redirect takes priority over a same-cycle pop and a same-cycle push; the response is discarded.
REQ-024 Redirect in S_REQ: the request is held until accepted, then drop <= 1; the following response is discarded and drop cleared; -> S_IDLE.
REQ-025 Redirect in S_WAIT without a response: drop <= 1; stay in S_WAIT until the response, then discard it, clear drop, -> S_IDLE.
REQ-026 Redirect in S_IDLE or S_HALT: -> S_IDLE with the new pc.
REQ-027 Minimum latency: a request is accepted in cycle N, the response arrives in N+1, and inst_valid = 1 in N+2.

Reset
REQ-028 On rst: state=S_IDLE, pc=RESET_PC, req_addr=RESET_PC, drop=0, count=0.
REQ-029 During rst, if_req_valid=0 and inst_valid=0; inst and inst_addr are 0.
REQ-030 Reset mid-transaction discards the outstanding request; a late response while in S_IDLE is ignored.
REQ-031 First if_req_valid=1 occurs two cycles after rst deasserts (S_IDLE, then S_REQ).

Configuration
REQ-032 Macro FETCH_HALT_EN defined: a non-dropped response with opcode [6:0] == 7'h6b is pushed normally, then the FSM enters S_HALT; no requests are issued until a redirect or reset.
REQ-033 Macro FETCH_HALT_EN undefined: S_HALT is unreachable and opcode 7'h6b is fetched like any other instruction.

Verification
REQ-034 Reset, memory always ready, 1-cycle response, inst_ready=1 -> if_req_addr sequence 0x80000000, 0x80000004, 0x80000008; each inst_addr matches its data.
REQ-035 inst_ready=0 for 10 cycles -> count saturates at 2; no request while full; entries 0x80000000/0x80000004 are delivered in order after release.
REQ-036 Redirect to 0x80001002 in S_WAIT; response arrives 3 cycles later -> response dropped; next if_req_addr is 0x80001000; inst_valid is 0 in the meantime.
REQ-037 Redirect in the same cycle as if_resp_valid and a pop with count=1 -> count=0 the next cycle; response not delivered.
REQ-038 pc=0xFFFF_FFFF_FFFF_FFFC accepted -> next if_req_addr is 0x0.
REQ-039 FETCH_HALT_EN: fetch 0x0000006b -> delivered to decode; if_req_valid stays 0 for 20 cycles; a redirect to 0x80000100 resumes fetching at that address.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction fetch, one outstanding request, 2-entry instruction buffer.
// Optional macro FETCH_HALT_EN: a fetched opcode 7'h6b parks the fetcher in S_HALT.
module if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        if_req_valid,
  input  logic        if_req_ready,
  output logic [63:0] if_req_addr,
  input  logic        if_resp_valid,
  input  logic [31:0] if_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_addr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_addr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HALT
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [63:0] pc;
  logic [63:0] pc_nx;
  logic [63:0] req_addr;
  logic [63:0] req_addr_nx;
  logic        drop;
  logic        drop_nx;
  logic [31:0] fifo_inst [2];
  logic [63:0] fifo_addr [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        push;
  logic        pop;
  logic        halt_op;
  logic [63:0] redir_pc;

  assign redir_pc = redirect_addr & ~64'd3;

`ifdef FETCH_HALT_EN
  assign halt_op = (if_resp_data[6:0] == 7'h6b);
`else
  assign halt_op = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    req_addr_nx = req_addr;
    drop_nx     = drop;
    push        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (redirect_valid) begin
          pc_nx = redir_pc;
        end else if (count <= 2'd1) begin
          state_nx    = S_REQ;
          req_addr_nx = pc;
        end
      end
      S_REQ: begin
        // a redirected request still has to complete; its answer is dropped
        if (redirect_valid) begin
          pc_nx   = redir_pc;
          drop_nx = 1'b1;
        end
        if (if_req_ready) begin
          state_nx = S_WAIT;
          if (!drop && !redirect_valid)
            pc_nx = req_addr + 64'd4;
        end
      end
      S_WAIT: begin
        if (redirect_valid)
          pc_nx = redir_pc;
        if (if_resp_valid) begin
          state_nx = S_IDLE;
          drop_nx  = 1'b0;
          if (!drop && !redirect_valid) begin
            push = 1'b1;
            if (halt_op)
              state_nx = S_HALT;
          end
        end else if (redirect_valid) begin
          drop_nx = 1'b1;
        end
      end
      S_HALT: begin
        if (redirect_valid) begin
          state_nx = S_IDLE;
          pc_nx    = redir_pc;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign inst_valid   = (count != 2'd0) && !rst;
  assign pop          = inst_valid && inst_ready && !redirect_valid;
  assign if_req_valid = (state == S_REQ) && !rst;
  assign if_req_addr  = req_addr;
  assign inst         = inst_valid ? fifo_inst[rd_ptr] : 32'd0;
  assign inst_addr    = inst_valid ? fifo_addr[rd_ptr] : 64'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      drop     <= 1'b0;
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      req_addr <= req_addr_nx;
      drop     <= drop_nx;
      if (redirect_valid) begin
        count  <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push)
          wr_ptr <= ~wr_ptr;
        if (pop)
          rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= if_resp_data;
      fifo_addr[wr_ptr] <= req_addr;
    end
  end

endmodule
